// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op encoding, FSM states and op-decode helpers for div_unit
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete without iterating.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             is_rem, q_neg, r_neg;

  div_op_t          op_in;
  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, early;

  assign op_in     = div_op_t'(op);
  assign in_signed = op_is_signed(op_in);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

`ifdef DIV_EARLY_OUT_EN
  logic             div_zero, sgn_ovf;
  logic [WIDTH-1:0] early_result;

  assign div_zero = (b == '0);
  assign sgn_ovf  = in_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign early    = div_zero | sgn_ovf;

  always_comb begin
    early_result = op_is_rem(op_in) ? a : '1;
    if (!div_zero) early_result = op_is_rem(op_in) ? '0 : a;
  end
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, keep the trial difference if it did not borrow.
  logic [WIDTH:0]   rem_sh, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;

  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign fits     = ~trial[WIDTH];
  assign rem_step = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], fits};
  assign q_fix    = q_neg ? -quo_step : quo_step;
  assign r_fix    = r_neg ? -rem_step : rem_step;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = early ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (count == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = early ? S_DONE : S_CALC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // result only changes when an operation finishes, so it holds through the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      count  <= LAST_COUNT;
      rem    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      is_rem <= op_is_rem(op_in);
      q_neg  <= (a_neg ^ b_neg) && (b != '0);
      r_neg  <= a_neg;
`ifdef DIV_EARLY_OUT_EN
      if (early) result <= early_result;
`endif
    end else if (state == S_CALC) begin
      rem <= rem_step;
      quo <= quo_step;
      if (count != '0) count  <= count - CW'(1);
      else             result <= is_rem ? r_fix : q_fix;
    end
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

endmodule
